fetch_stage: RTL

//  MIPS instruction-fetch stage: owns the PC, drives the byte address into the

---
 rtl/fetch_stage.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// MIPS instruction-fetch stage. It holds the PC and drives it as the byte
// address of a combinational instruction memory. The returned word is
// captured into the IF/ID pipeline register one clock later. Stall, flush and
// branch/jump redirects resolved in ID steer the next PC and IF/ID contents.
//
// Optional feature macro: FETCH_PERF_CNT_EN
//   When defined, the outputs fetch_count and stall_count are added. These are
//   32-bit wrapping performance counters.
//
// Parameters
//   RESET_PC      PC value loaded on reset
//   IMEM_BYTES    instruction memory size in bytes (multiple of 4)
//
// Ports
//   clk            in   clock, rising edge
//   reset          in   asynchronous reset, active-high
//   stall          in   hold PC and IF/ID
//   flush          in   squash IF/ID on next edge
//   branch_taken   in   taken branch resolved in ID
//   branch_target  in   byte address of branch target
//   jump           in   ID holds a j instruction
//   jump_index     in   instr[25:0] of that j
//   imem_addr      out  byte address to instruction memory (= pc)
//   imem_data      in   instruction word, combinational
//   pc             out  current PC
//   if_id_instr    out  captured instruction
//   if_id_pc4      out  captured PC+4
//   if_id_valid    out  IF/ID holds a real instruction
//   if_id_fault    out  captured fetch was out of range or misaligned
//   fetch_count    out  (FETCH_PERF_CNT_EN) edges that loaded a valid IF/ID
//   stall_count    out  (FETCH_PERF_CNT_EN) edges with stall asserted
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count,
`endif
    output logic        if_id_fault
);

    // Highest legal word address
    localparam logic [31:0] LAST_WORD_ADDR = 32'(IMEM_BYTES) - 32'd4;

    // A fetch faults when the address is misaligned or past the last word.
    function automatic logic fetch_fault(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr > LAST_WORD_ADDR);
    endfunction

    logic [31:0] pc_r;
    logic [31:0] instr_r;
    logic [31:0] pc4_r;
    logic        valid_r;
    logic        fault_r;

    logic [31:0] pc_plus4_s;
    logic        fault_s;
    logic [31:0] pc_next_s;
    logic [31:0] instr_next_s;
    logic [31:0] pc4_next_s;
    logic        valid_next_s;
    logic        fault_next_s;

    // Next-state selection: stall > jump > branch > flush > sequential fetch
    always_comb begin
        pc_plus4_s   = pc_r + 32'd4;
        fault_s      = fetch_fault(pc_r);
        pc_next_s    = pc_r;
        instr_next_s = instr_r;
        pc4_next_s   = pc4_r;
        valid_next_s = valid_r;
        fault_next_s = fault_r;
        if (stall) begin
            // ID re-presents any redirect once the stall clears.
            pc_next_s    = pc_r;
            instr_next_s = instr_r;
            pc4_next_s   = pc4_r;
            valid_next_s = valid_r;
            fault_next_s = fault_r;
        end else if (jump) begin
            // Jump region comes from the PC+4 of the j sitting in IF/ID.
            pc_next_s    = {pc4_r[31:28], jump_index, 2'b00};
            instr_next_s = 32'h0000_0000;
            pc4_next_s   = 32'h0000_0000;
            valid_next_s = 1'b0;
            fault_next_s = 1'b0;
        end else if (branch_taken) begin
            pc_next_s    = branch_target;
            instr_next_s = 32'h0000_0000;
            pc4_next_s   = 32'h0000_0000;
            valid_next_s = 1'b0;
            fault_next_s = 1'b0;
        end else if (flush) begin
            pc_next_s    = pc_plus4_s;
            instr_next_s = 32'h0000_0000;
            pc4_next_s   = 32'h0000_0000;
            valid_next_s = 1'b0;
            fault_next_s = 1'b0;
        end else begin
            // A faulting fetch still advances; the bad word is replaced by a NOP.
            pc_next_s    = pc_plus4_s;
            instr_next_s = fault_s ? 32'h0000_0000 : imem_data;
            pc4_next_s   = pc_plus4_s;
            valid_next_s = ~fault_s;
            fault_next_s = fault_s;
        end
    end

    // PC and IF/ID pipeline register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r    <= RESET_PC;
            instr_r <= 32'h0000_0000;
            pc4_r   <= 32'h0000_0000;
            valid_r <= 1'b0;
            fault_r <= 1'b0;
        end else begin
            pc_r    <= pc_next_s;
            instr_r <= instr_next_s;
            pc4_r   <= pc4_next_s;
            valid_r <= valid_next_s;
            fault_r <= fault_next_s;
        end
    end

    assign pc          = pc_r;
    assign imem_addr   = pc_r;
    assign if_id_instr = instr_r;
    assign if_id_pc4   = pc4_r;
    assign if_id_valid = valid_r;
    assign if_id_fault = fault_r;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_r;
    logic [31:0] stall_cnt_r;
    logic        fetch_inc_s;

    // A valid load happens only on a non-stalled edge that captures a real word.
    always_comb begin
        fetch_inc_s = (~stall) & valid_next_s;
    end

    // Performance counters, wrapping at 2^32
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt_r <= 32'h0000_0000;
            stall_cnt_r <= 32'h0000_0000;
        end else begin
            fetch_cnt_r <= fetch_cnt_r + {31'd0, fetch_inc_s};
            stall_cnt_r <= stall_cnt_r + {31'd0, stall};
        end
    end

    assign fetch_count = fetch_cnt_r;
    assign stall_count = stall_cnt_r;
`endif

endmodule
